// File: rtl/toggle_hs_rx_pkg.sv
// Shared defaults, width derivation and FSM state type for the toggle-handshake receiver.
package toggle_hs_rx_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;

  // Occupancy counter must hold 0..DEPTH inclusive, hence one extra bit.
  function automatic int cw_of(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } hs_state_t;

endpackage

// File: rtl/toggle_hs_rx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head word is visible combinationally.
module sync_fifo
  import toggle_hs_rx_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW   = cw_of(DEPTH),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_rst) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/toggle_hs_rx.sv
// Two-phase (toggle) handshake receiver feeding a FWFT FIFO drained by a valid/ready port.
module toggle_hs_rx
  import toggle_hs_rx_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW   = cw_of(DEPTH)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Req,
  input  logic [DW-1:0] Data,
  output logic          Ack,
  output logic [DW-1:0] Out_Data,
  output logic          Out_Valid,
  input  logic          Out_Ready,
  output logic [CW-1:0] Count,
  output logic          Overrun
);

  hs_state_t r_state;
  hs_state_t w_next_state;
  logic      r_ack;
  logic      r_req_q;
  logic      r_overrun;
  logic      w_pending;
  logic      w_pop;
  logic      w_space;
  logic      w_accept;
  logic      w_full;
  logic      w_empty;

  assign w_pending = Req ^ r_ack;
  assign w_pop     = Out_Valid & Out_Ready;
  assign w_space   = ~w_full | w_pop;

  always_comb begin
    w_next_state = ST_IDLE;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE, ST_PEND: begin
        // A stalled word may also vanish when the sender toggles back (overrun).
        if (w_pending) begin
          if (w_space) w_accept     = 1'b1;
          else         w_next_state = ST_PEND;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= ST_IDLE;
      r_ack     <= 1'b0;
      r_req_q   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_req_q <= Req;
      if (w_accept) r_ack <= ~r_ack;
      if ((Req ^ r_req_q) & (r_req_q ^ r_ack)) r_overrun <= 1'b1;
    end
  end

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_wdata (Data),
    .o_rdata (Out_Data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (Count)
  );

  assign Ack       = r_ack;
  assign Out_Valid = ~w_empty;
  assign Overrun   = r_overrun;

endmodule

// File: tb/tb_toggle_hs_rx.sv
// Directed bench for toggle_hs_rx: scoreboard queue of expected words plus direct status checks.
module tb_toggle_hs_rx;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Req;
  logic [7:0] Data;
  logic       Ack;
  logic [7:0] Out_Data;
  logic       Out_Valid;
  logic       Out_Ready;
  logic [2:0] Count;
  logic       Overrun;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];
  logic       exp_ack;

  toggle_hs_rx #(.DW(8), .DEPTH(4)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Req       (Req),
    .Data      (Data),
    .Ack       (Ack),
    .Out_Data  (Out_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Count     (Count),
    .Overrun   (Overrun)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a word; expected data goes on the scoreboard only if it will be delivered.
  task automatic offer(input logic [7:0] d, input bit expect_delivery);
    Data = d;
    Req  = ~Req;
    if (expect_delivery) sb.push_back(d);
  endtask

  task automatic drain(input string name);
    Out_Ready = 1'b1;
    for (int k = 0; k < 20 && Out_Valid; k++) tick();
    Out_Ready = 1'b0;
    check({name, "_valid"}, 32'(Out_Valid), 0);
    check({name, "_count"}, 32'(Count), 0);
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  // Monitor: every word the consumer takes must match the head of the scoreboard.
  always @(negedge Clk) begin
    if (!Rst && Out_Valid && Out_Ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h expected no word", Out_Data);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (Out_Data !== e) begin
          n_fail++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h", Out_Data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; Req = 1'b0; Data = '0; Out_Ready = 1'b0; exp_ack = 1'b0;
    tick(); tick();
    check("rst_ack", 32'(Ack), 0);
    check("rst_count", 32'(Count), 0);
    check("rst_valid", 32'(Out_Valid), 0);
    check("rst_overrun", 32'(Overrun), 0);
    Rst = 1'b0;
    tick();

    // Single word
    offer(8'hA5, 1'b1); exp_ack = ~exp_ack;
    tick();
    check("single_ack", 32'(Ack), 32'(exp_ack));
    check("single_count", 32'(Count), 1);
    check("single_valid", 32'(Out_Valid), 1);
    check("single_data", 32'(Out_Data), 32'h A5);
    check("single_overrun", 32'(Overrun), 0);
    drain("single_drain");

    // Fill to full, fifth word stalls
    for (int i = 1; i <= 4; i++) begin
      offer(8'(i), 1'b1); exp_ack = ~exp_ack;
      tick();
      check("fill_ack", 32'(Ack), 32'(exp_ack));
    end
    check("fill_count", 32'(Count), 4);
    offer(8'h05, 1'b1);
    tick(); tick();
    check("stall_ack", 32'(Ack), 32'(exp_ack));
    check("stall_count", 32'(Count), 4);
    Out_Ready = 1'b1; exp_ack = ~exp_ack;
    tick();
    check("pushpop_full_count", 32'(Count), 4);
    check("pushpop_full_ack", 32'(Ack), 32'(exp_ack));

    // Streaming with continuous pops; pointers wrap
    for (int j = 0; j < 6; j++) begin
      offer(8'h10 + 8'(j), 1'b1); exp_ack = ~exp_ack;
      tick();
      check("stream_ack", 32'(Ack), 32'(exp_ack));
      check("stream_count", 32'(Count), 4);
    end
    drain("stream_drain");

    // Simultaneous push/pop at Count=1
    offer(8'h33, 1'b1); exp_ack = ~exp_ack;
    tick();
    Out_Ready = 1'b1;
    offer(8'h7E, 1'b1); exp_ack = ~exp_ack;
    tick();
    Out_Ready = 1'b0;
    check("pp1_count", 32'(Count), 1);
    check("pp1_data", 32'(Out_Data), 32'h7E);
    check("pp1_ack", 32'(Ack), 32'(exp_ack));
    drain("pp1_drain");

    // Protocol violation: toggle twice while stalled
    for (int i = 0; i < 4; i++) begin
      offer(8'h40 + 8'(i), 1'b1); exp_ack = ~exp_ack;
      tick();
    end
    offer(8'h44, 1'b0);
    tick();
    check("ovr_before", 32'(Overrun), 0);
    offer(8'h45, 1'b0);
    tick();
    check("ovr_set", 32'(Overrun), 1);
    check("ovr_count", 32'(Count), 4);
    check("ovr_ack", 32'(Ack), 32'(exp_ack));
    tick();
    check("ovr_ack_hold", 32'(Ack), 32'(exp_ack));
    check("ovr_count_hold", 32'(Count), 4);
    drain("ovr_drain");
    offer(8'h55, 1'b1); exp_ack = ~exp_ack;
    tick();
    check("ovr_sticky", 32'(Overrun), 1);
    check("ovr_traffic_ack", 32'(Ack), 32'(exp_ack));
    drain("ovr_traffic_drain");
    Rst = 1'b1; Req = 1'b0;
    tick();
    Rst = 1'b0; exp_ack = 1'b0;
    check("ovr_cleared", 32'(Overrun), 0);
    check("ovr_rst_ack", 32'(Ack), 0);

    // Reset mid-operation with a pending word, Req held high at release
    for (int i = 0; i < 3; i++) begin
      offer(8'h60 + 8'(i), 1'b1); exp_ack = ~exp_ack;
      tick();
    end
    check("mid_count3", 32'(Count), 3);
    Rst = 1'b1; Req = 1'b1; Data = 8'h66;
    sb.delete();
    tick();
    check("mid_rst_count", 32'(Count), 0);
    check("mid_rst_ack", 32'(Ack), 0);
    check("mid_rst_valid", 32'(Out_Valid), 0);
    Rst = 1'b0; Data = 8'h99; sb.push_back(8'h99); exp_ack = 1'b1;
    tick();
    check("release_ack", 32'(Ack), 32'(exp_ack));
    check("release_count", 32'(Count), 1);
    check("release_data", 32'(Out_Data), 32'h99);
    drain("release_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
